// File: rtl/fht_pkg.sv
// Shared types for the FHT I/O controller: FSM state encoding and frame-length helper.
package fht_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_UNLOAD
    } fht_state_e;

    // Four banks of 2^a_bit words each make up one frame.
    function automatic int unsigned fht_points(input int unsigned a_bit);
        return 32'd4 << a_bit;
    endfunction

endpackage

// File: rtl/fht_io_ctrl_if.sv
// Bundle of the controller's stream, bank and handshake signals, with ctrl/env views.
interface fht_io_ctrl_if #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
);
    logic [D_BIT-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [A_BIT-1:0] wr_addr;
    logic [D_BIT-1:0] wr_data;
    logic [3:0]       we;
    logic             start;
    logic             fht_rdy;
    logic             rd_en;
    logic [A_BIT-1:0] rd_addr;
    logic [D_BIT-1:0] rd_data_0;
    logic [D_BIT-1:0] rd_data_1;
    logic [D_BIT-1:0] rd_data_2;
    logic [D_BIT-1:0] rd_data_3;
    logic [D_BIT-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output in_ready, wr_addr, wr_data, we, start, rd_en, rd_addr,
               out_data, out_valid, busy,
        input  in_data, in_valid, fht_rdy, rd_data_0, rd_data_1, rd_data_2,
               rd_data_3, out_ready
    );

    modport slave (
        input  in_ready, wr_addr, wr_data, we, start, rd_en, rd_addr,
               out_data, out_valid, busy,
        output in_data, in_valid, fht_rdy, rd_data_0, rd_data_1, rd_data_2,
               rd_data_3, out_ready
    );
endinterface

// File: rtl/fht_io_skid.sv
// Two-entry output FIFO; a push and a pop may share a cycle even when full.
module fht_io_skid #(
    parameter int D_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [D_BIT-1:0] data_i,
    input  logic             pop_i,
    output logic [D_BIT-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);
    logic [D_BIT-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             pop_do;

    assign pop_do  = pop_i && (cnt_q != 2'd0);
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_do) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_do};
        end
    end
endmodule

// File: rtl/fht_io_ctrl.sv
// Frame loader/unloader around an FHT core: fills four banks, kicks the core,
// then streams results out through a credit-limited two-entry FIFO.
module fht_io_ctrl
    import fht_pkg::*;
#(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic [A_BIT-1:0] oWR_ADDR,
    output logic [D_BIT-1:0] oWR_DATA,
    output logic [3:0]       oWE,
    output logic             oSTART,
    input  logic             iRDY,
    output logic             oRD_EN,
    output logic [A_BIT-1:0] oRD_ADDR,
    input  logic [D_BIT-1:0] iRD_DATA_0,
    input  logic [D_BIT-1:0] iRD_DATA_1,
    input  logic [D_BIT-1:0] iRD_DATA_2,
    input  logic [D_BIT-1:0] iRD_DATA_3,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oBUSY
);
    localparam int unsigned POINTS = fht_points(A_BIT);
    localparam int          K_W    = A_BIT + 2;

    fht_state_e       state_q;
    logic [K_W-1:0]   k_q;
    logic [K_W:0]     j_q;        // reads issued; MSB set once the frame is fully read
    logic [K_W-1:0]   pop_cnt_q;
    logic             inflight_q;
    logic [1:0]       sel_q;

    logic             accept;
    logic             pop;
    logic             last_pop;
    logic [1:0]       fifo_cnt;
    logic [2:0]       outstanding;
    logic [D_BIT-1:0] rd_mux;

    assign accept      = (state_q == ST_LOAD) && iVALID;
    assign pop         = oVALID && iREADY;
    assign last_pop    = pop && (pop_cnt_q == K_W'(POINTS - 1));
    assign outstanding = {1'b0, fifo_cnt} + {2'b00, inflight_q};

    assign oREADY   = (state_q == ST_LOAD);
    assign oBUSY    = (state_q != ST_LOAD);
    assign oSTART   = (state_q == ST_START);
    assign oWE      = accept ? (4'b0001 << k_q[1:0]) : 4'b0000;
    assign oWR_ADDR = k_q[K_W-1:2];
    assign oWR_DATA = iDATA;
    assign oRD_EN   = (state_q == ST_UNLOAD) && !j_q[K_W] && (outstanding < 3'd2);
    assign oRD_ADDR = j_q[K_W-1:2];

    always_comb begin
        rd_mux = iRD_DATA_0;
        case (sel_q)
            2'd1:    rd_mux = iRD_DATA_1;
            2'd2:    rd_mux = iRD_DATA_2;
            2'd3:    rd_mux = iRD_DATA_3;
            default: rd_mux = iRD_DATA_0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q    <= ST_LOAD;
            k_q        <= '0;
            j_q        <= '0;
            pop_cnt_q  <= '0;
            inflight_q <= 1'b0;
            sel_q      <= 2'd0;
        end else begin
            inflight_q <= oRD_EN;
            if (oRD_EN) begin
                sel_q <= j_q[1:0];
                j_q   <= j_q + 1'b1;
            end
            if (pop) pop_cnt_q <= pop_cnt_q + 1'b1;

            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        k_q <= k_q + 1'b1;   // wraps to 0 after the last sample
                        if (k_q == K_W'(POINTS - 1)) state_q <= ST_START;
                    end
                end
                ST_START:     state_q <= ST_WAIT_LOW;
                ST_WAIT_LOW:  if (!iRDY) state_q <= ST_WAIT_HIGH;
                ST_WAIT_HIGH: if (iRDY)  state_q <= ST_UNLOAD;
                ST_UNLOAD: begin
                    if (last_pop) begin
                        state_q   <= ST_LOAD;
                        j_q       <= '0;
                        pop_cnt_q <= '0;
                    end
                end
                default:      state_q <= ST_LOAD;
            endcase
        end
    end

    fht_io_skid #(.D_BIT(D_BIT)) u_skid (
        .clk     (iCLK),
        .rst_n   (iRESET),
        .push_i  (inflight_q),
        .data_i  (rd_mux),
        .pop_i   (iREADY),
        .data_o  (oDATA),
        .valid_o (oVALID),
        .count_o (fifo_cnt)
    );
endmodule

// File: tb/tb_fht_io_ctrl.sv
// Directed-sequence bench for fht_io_ctrl with randomized data and backpressure.
module tb_fht_io_ctrl;
    import fht_pkg::*;

    localparam int A_BIT  = 2;
    localparam int D_BIT  = 16;
    localparam int POINTS = int'(fht_points(A_BIT));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fht_io_ctrl_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

    fht_io_ctrl #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
        .iCLK       (clk),
        .iRESET     (rst_n),
        .iDATA      (bus.in_data),
        .iVALID     (bus.in_valid),
        .oREADY     (bus.in_ready),
        .oWR_ADDR   (bus.wr_addr),
        .oWR_DATA   (bus.wr_data),
        .oWE        (bus.we),
        .oSTART     (bus.start),
        .iRDY       (bus.fht_rdy),
        .oRD_EN     (bus.rd_en),
        .oRD_ADDR   (bus.rd_addr),
        .iRD_DATA_0 (bus.rd_data_0),
        .iRD_DATA_1 (bus.rd_data_1),
        .iRD_DATA_2 (bus.rd_data_2),
        .iRD_DATA_3 (bus.rd_data_3),
        .oDATA      (bus.out_data),
        .oVALID     (bus.out_valid),
        .iREADY     (bus.out_ready),
        .oBUSY      (bus.busy)
    );

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;

    // Bank model: wmem captures what the block writes, rmem holds the transform result.
    logic [D_BIT-1:0] wmem  [POINTS];
    logic [D_BIT-1:0] rmem  [POINTS];
    logic [D_BIT-1:0] rd_q  [4];
    logic [D_BIT-1:0] exp_in [POINTS];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.we[b]) wmem[int'(bus.wr_addr) * 4 + b] <= bus.wr_data;
            if (bus.rd_en) rd_q[b] <= rmem[int'(bus.rd_addr) * 4 + b];
        end
        if (bus.start) start_cnt <= start_cnt + 1;
    end

    assign bus.rd_data_0 = rd_q[0];
    assign bus.rd_data_1 = rd_q[1];
    assign bus.rd_data_2 = rd_q[2];
    assign bus.rd_data_3 = rd_q[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.fht_rdy = 1'b1;
        #1;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_we", bus.we, 0);
        chk("rst_start", bus.start, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", bus.in_ready, 1);
    endtask

    task automatic load(input int n, input bit seq_data, input bit gaps);
        int k = 0;
        int guard = 0;
        bit v;
        logic [D_BIT-1:0] d;
        while (k < n && guard < 1000) begin
            @(negedge clk);
            guard++;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = seq_data ? D_BIT'(k) : D_BIT'($urandom);
            bus.in_valid = v;
            bus.in_data  = d;
            #1;
            chk("load_ready", bus.in_ready, 1);
            if (v) begin
                chk("load_we", bus.we, 32'd1 << (k % 4));
                chk("load_wr_addr", bus.wr_addr, k / 4);
                chk("load_wr_data", bus.wr_data, d);
                exp_in[k] = d;
                k++;
            end else begin
                chk("load_we_idle", bus.we, 0);
            end
        end
        chk("load_count", k, n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1;
    endtask

    task automatic run_frame(input bit seq_data, input bit gaps, input int low,
                             input bit rand_rdy, input int lim, input int exp_starts);
        int c = 0;
        int popped = 0;
        int issued = 0;
        int first = -1;
        bit rdy;
        load(POINTS, seq_data, gaps);
        chk("start_pulse", bus.start, 1);
        chk("start_ready", bus.in_ready, 0);
        chk("start_busy", bus.busy, 1);
        for (int i = 0; i < POINTS; i++) chk("bank_content", wmem[i], exp_in[i]);
        for (int j = 0; j < POINTS; j++) rmem[j] = seq_data ? D_BIT'(100 + j) : D_BIT'($urandom);
        for (int i = 0; i < low; i++) begin
            @(negedge clk);
            bus.fht_rdy  = 1'b0;
            bus.in_valid = 1'b1;
            #1;
            chk("wait_start", bus.start, 0);
            chk("wait_rd_en", bus.rd_en, 0);
            chk("wait_we", bus.we, 0);
        end
        @(negedge clk);
        bus.fht_rdy = 1'b1;
        #1;
        chk("rise_rd_en", bus.rd_en, 0);
        while (popped < lim && c < 500) begin
            @(negedge clk);
            c++;
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            bus.in_valid  = 1'($urandom_range(0, 1));
            #1;
            chk("unload_we", bus.we, 0);
            chk("unload_start", bus.start, 0);
            if (bus.rd_en) begin
                issued++;
                chk("outstanding_le2", ((issued - popped) <= 2) ? 1 : 0, 1);
            end
            if (bus.out_valid && first < 0) first = c;
            if (bus.out_valid && rdy) begin
                chk("out_data", bus.out_data, rmem[popped]);
                popped++;
            end
        end
        chk("first_valid_latency", first, 3);
        chk("popped_count", popped, lim);
        if (lim == POINTS) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            #1;
            chk("back_ready", bus.in_ready, 1);
            chk("back_busy", bus.busy, 0);
            chk("back_valid", bus.out_valid, 0);
            chk("start_count", start_cnt, exp_starts);
        end
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.fht_rdy   = 1'b1;
        bus.out_ready = 1'b0;

        do_reset();
        run_frame(1'b1, 1'b0, 5, 1'b0, POINTS, 1);   // sequential samples, results 100+j
        run_frame(1'b0, 1'b1, 1, 1'b1, POINTS, 2);   // single-cycle iRDY pulse, random backpressure

        load(8, 1'b0, 1'b1);                          // reset mid-load
        do_reset();
        chk("no_start_after_rst_load", start_cnt, 2);
        run_frame(1'b0, 1'b1, 3, 1'b1, POINTS, 3);

        run_frame(1'b0, 1'b0, 2, 1'b1, 5, 4);         // reset mid-unload
        do_reset();
        chk("start_count_rst_unload", start_cnt, 4);
        run_frame(1'b0, 1'b1, 4, 1'b1, POINTS, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
